// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type encodings, output-port codes and default widths.
package noc_pkg;
    localparam int FLIT_W_DEF  = 35;
    localparam int ENTRY_W_DEF = 32;
    localparam int PORT_W_DEF  = 3;
    localparam int VCH_W_DEF   = 1;
    localparam int DEPTH_DEF   = 4;

    typedef enum logic [1:0] {
        FT_BODY     = 2'b00,
        FT_HEAD     = 2'b01,
        FT_TAIL     = 2'b10,
        FT_HEADTAIL = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        PORT_N     = 3'd0,
        PORT_E     = 3'd1,
        PORT_S     = 3'd2,
        PORT_W     = 3'd3,
        PORT_LOCAL = 3'd4
    } port_e;

    // Bit 0 of the type marks a packet start, bit 1 a packet end.
    function automatic logic is_head(input logic [1:0] t);
        return t[0];
    endfunction

    function automatic logic is_tail(input logic [1:0] t);
        return t[1];
    endfunction
endpackage

// File: rtl/flit_fifo.sv
// Circular flit buffer with extra-bit wrapping pointers; the front entry is readable combinationally.
module flit_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  front,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         wr_en;
    logic         rd_en;

    assign count = wr_ptr_reg - rd_ptr_reg;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign front = mem[rd_ptr_reg[AW-1:0]];

    // A push into a full buffer is still taken when the front leaves on the same edge.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/input_vc_buffer.sv
// Input VC buffer: buffers upstream flits, routes each head, then streams the packet under switch grants.
module input_vc_buffer
    import noc_pkg::*;
#(
    parameter int FLIT_W  = FLIT_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ENTRY_W = ENTRY_W_DEF,
    parameter int PORT_W  = PORT_W_DEF,
    parameter int VCH_W   = VCH_W_DEF,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [FLIT_W-1:0]  in_flit,
    input  logic [VCH_W-1:0]   in_vch,
    output logic               credit_out,
    output logic [ENTRY_W-1:0] rc_addr,
    output logic [ENTRY_W-1:0] rc_ivch,
    output logic               rc_en,
    input  logic [PORT_W-1:0]  rc_port,
    input  logic [VCH_W-1:0]   rc_ovch,
    output logic               sw_req,
    output logic [PORT_W-1:0]  sw_port,
    output logic [VCH_W-1:0]   sw_ovch,
    input  logic               sw_grant,
    output logic               out_valid,
    output logic [FLIT_W-1:0]  out_flit,
    output logic [CNT_W-1:0]   count,
    output logic               err
);
    typedef enum logic [1:0] {S_IDLE, S_RC, S_REQ, S_ACTIVE} state_e;

    state_e             state_reg;
    logic [PORT_W-1:0]  sw_port_reg;
    logic [VCH_W-1:0]   sw_ovch_reg;
    logic [VCH_W-1:0]   vch_reg;
    logic               err_reg;

    logic [FLIT_W-1:0]  front;
    logic               full;
    logic               empty;
    logic [1:0]         front_type;
    logic [1:0]         in_type;
    logic               discard_pop;
    logic               grant_pop;
    logic               pop;
    logic               push_drop;
    logic               push_ok;

    flit_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .din   (in_flit),
        .front (front),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign front_type = front[FLIT_W-1 -: 2];
    assign in_type    = in_flit[FLIT_W-1 -: 2];

    // Orphan body/tail flits at the front while idle are flushed without a switch request.
    assign discard_pop = (state_reg == S_IDLE) && !empty && !is_head(front_type);
    assign grant_pop   = ((state_reg == S_REQ) || (state_reg == S_ACTIVE)) && sw_grant && !empty;
    assign pop         = discard_pop || grant_pop;
    assign push_drop   = in_valid && full && !pop;
    assign push_ok     = in_valid && !push_drop;

    assign credit_out = pop;
    assign out_valid  = grant_pop;
    assign out_flit   = front;
    assign rc_addr    = front[ENTRY_W-1:0];
    assign rc_ivch    = {{(ENTRY_W-VCH_W){1'b0}}, vch_reg};
    assign rc_en      = (state_reg == S_RC);
    assign sw_req     = (state_reg == S_REQ) || ((state_reg == S_ACTIVE) && !empty);
    assign sw_port    = sw_port_reg;
    assign sw_ovch    = sw_ovch_reg;
    assign err        = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            sw_port_reg <= '0;
            sw_ovch_reg <= '0;
            vch_reg     <= '0;
            err_reg     <= 1'b0;
        end else begin
            if (push_ok && is_head(in_type)) begin
                vch_reg <= in_vch;
            end
            if (push_drop || discard_pop) begin
                err_reg <= 1'b1;
            end
            case (state_reg)
                // An empty buffer looks at the arriving flit so a fresh head is routed the next cycle.
                S_IDLE: begin
                    if (!empty ? is_head(front_type) : (in_valid && is_head(in_type))) begin
                        state_reg <= S_RC;
                    end
                end
                S_RC: begin
                    sw_port_reg <= rc_port;
                    sw_ovch_reg <= rc_ovch;
                    state_reg   <= S_REQ;
                end
                S_REQ: begin
                    if (grant_pop) begin
                        state_reg <= is_tail(front_type) ? S_IDLE : S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (grant_pop && is_tail(front_type)) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_vc_buffer.sv
// Self-checking bench for input_vc_buffer: queue-based packet model plus directed and random traffic.
module tb_input_vc_buffer;
    localparam int FLIT_W  = 35;
    localparam int DEPTH   = 4;
    localparam int ENTRY_W = 32;
    localparam int PORT_W  = 3;
    localparam int VCH_W   = 1;

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    // Model phases of the packet currently at the buffer front.
    localparam int P_IDLE   = 0;
    localparam int P_ROUTE  = 1;
    localparam int P_WAIT   = 2;
    localparam int P_STREAM = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic [FLIT_W-1:0]  in_flit = '0;
    logic [VCH_W-1:0]   in_vch = '0;
    logic               credit_out;
    logic [ENTRY_W-1:0] rc_addr;
    logic [ENTRY_W-1:0] rc_ivch;
    logic               rc_en;
    logic [PORT_W-1:0]  rc_port = '0;
    logic [VCH_W-1:0]   rc_ovch = '0;
    logic               sw_req;
    logic [PORT_W-1:0]  sw_port;
    logic [VCH_W-1:0]   sw_ovch;
    logic               sw_grant = 1'b0;
    logic               out_valid;
    logic [FLIT_W-1:0]  out_flit;
    logic [2:0]         count;
    logic               err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    input_vc_buffer #(
        .FLIT_W(FLIT_W), .DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .PORT_W(PORT_W), .VCH_W(VCH_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_vch(in_vch),
        .credit_out(credit_out), .rc_addr(rc_addr), .rc_ivch(rc_ivch), .rc_en(rc_en),
        .rc_port(rc_port), .rc_ovch(rc_ovch), .sw_req(sw_req), .sw_port(sw_port),
        .sw_ovch(sw_ovch), .sw_grant(sw_grant), .out_valid(out_valid), .out_flit(out_flit),
        .count(count), .err(err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [FLIT_W-1:0] mq[$];
    int                mphase;
    logic [VCH_W-1:0]  mvch;
    logic [PORT_W-1:0] mport;
    logic [VCH_W-1:0]  movch;
    logic              merr;

    task automatic model_reset();
        mq.delete();
        mphase = P_IDLE;
        mvch   = '0;
        mport  = '0;
        movch  = '0;
        merr   = 1'b0;
    endtask

    task automatic model_step();
        logic [FLIT_W-1:0] fr;
        logic [1:0]        ft;
        logic [1:0]        it;
        bit                emp;
        bit                disc;
        bit                send;
        bit                accept;
        int                nphase;
        emp  = (mq.size() == 0);
        fr   = emp ? '0 : mq[0];
        ft   = fr[FLIT_W-1 -: 2];
        it   = in_flit[FLIT_W-1 -: 2];
        disc = (mphase == P_IDLE) && !emp && (ft == T_BODY || ft == T_TAIL);
        send = (mphase == P_WAIT || mphase == P_STREAM) && sw_grant && !emp;

        chk("rc_en", rc_en, mphase == P_ROUTE);
        chk("sw_req", sw_req, mphase == P_WAIT || (mphase == P_STREAM && !emp));
        chk("out_valid", out_valid, send);
        chk("credit_out", credit_out, disc || send);
        chk("count", count, mq.size());
        chk("err", err, merr);
        chk("sw_port", sw_port, mport);
        chk("sw_ovch", sw_ovch, movch);
        chk("rc_ivch", rc_ivch, 32'(mvch));
        if (!emp) begin
            chk("out_flit", out_flit, fr);
            chk("rc_addr", rc_addr, fr[ENTRY_W-1:0]);
        end

        accept = in_valid && (mq.size() < DEPTH || disc || send);
        if ((in_valid && !accept) || disc) merr = 1'b1;
        if (accept && (it == T_HEAD || it == T_HT)) mvch = in_vch;

        nphase = mphase;
        case (mphase)
            P_IDLE: begin
                if (!emp && (ft == T_HEAD || ft == T_HT)) nphase = P_ROUTE;
                else if (emp && accept && (it == T_HEAD || it == T_HT)) nphase = P_ROUTE;
            end
            P_ROUTE: begin
                mport  = rc_port;
                movch  = rc_ovch;
                nphase = P_WAIT;
            end
            P_WAIT:   if (send) nphase = (ft == T_HT) ? P_IDLE : P_STREAM;
            P_STREAM: if (send && (ft == T_TAIL || ft == T_HT)) nphase = P_IDLE;
            default:  nphase = P_IDLE;
        endcase
        mphase = nphase;

        if (disc || send) void'(mq.pop_front());
        if (accept) mq.push_back(in_flit);
    endtask

    always begin
        @(negedge clk or posedge rst);
        #1;
        if (rst) model_reset();
        else model_step();
    end

    // ---------------- stimulus ----------------
    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t);
        logic [32:0] p;
        p = {1'($urandom_range(0, 1)), 32'($urandom)};
        return {t, p};
    endfunction

    task automatic drive(input logic v, input logic [FLIT_W-1:0] f, input logic [VCH_W-1:0] vc,
                         input logic g, input logic [PORT_W-1:0] p, input logic [VCH_W-1:0] ov);
        @(negedge clk);
        in_valid = v;
        in_flit  = f;
        in_vch   = vc;
        sw_grant = g;
        rc_port  = p;
        rc_ovch  = ov;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        sw_grant = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [FLIT_W-1:0] f0, f1, f2, f3;
    logic [FLIT_W-1:0] pend[$];
    int credits;

    initial begin
        model_reset();
        do_reset();

        // Single head+tail flit into an empty buffer.
        f0 = mk(T_HT);
        drive(1, f0, 1'b1, 0, 3'd4, 1'b0); look();
        chk("t1_c0_rc_en", rc_en, 1'b0);
        drive(0, '0, 1'b0, 0, 3'd4, 1'b1); look();
        chk("t1_c1_rc_en", rc_en, 1'b1);
        chk("t1_c1_rc_ivch", rc_ivch, 32'd1);
        drive(0, '0, 1'b0, 1, 3'd2, 1'b0); look();
        chk("t1_c2_sw_req", sw_req, 1'b1);
        chk("t1_c2_sw_port", sw_port, 3'd4);
        chk("t1_c2_sw_ovch", sw_ovch, 1'b1);
        chk("t1_c2_out_valid", out_valid, 1'b1);
        chk("t1_c2_credit", credit_out, 1'b1);
        chk("t1_c2_out_flit", out_flit, f0);
        drive(0, '0, 1'b0, 0, 3'd0, 1'b0); look();
        chk("t1_c3_count", count, 3'd0);
        chk("t1_c3_sw_req", sw_req, 1'b0);

        // Four-flit packet with grant held high throughout.
        f0 = mk(T_HEAD); f1 = mk(T_BODY); f2 = mk(T_BODY); f3 = mk(T_TAIL);
        credits = 0;
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: drive(1, f0, 1'b0, 1, 3'd1, 1'b0);
                1: drive(1, f1, 1'b0, 1, 3'd1, 1'b0);
                2: drive(1, f2, 1'b0, 1, 3'd3, 1'b0);
                3: drive(1, f3, 1'b0, 1, 3'd3, 1'b0);
                default: drive(0, '0, 1'b0, 1, 3'd2, 1'b0);
            endcase
            look();
            chk($sformatf("t2_c%0d_out_valid", c), out_valid, (c >= 2 && c <= 5));
            if (credit_out) credits++;
            if (c >= 2 && c <= 5) chk($sformatf("t2_c%0d_sw_port", c), sw_port, 3'd1);
            if (c == 2) chk("t2_head_out", out_flit, f0);
            if (c == 5) chk("t2_tail_out", out_flit, f3);
        end
        chk("t2_credits", credits, 4);
        chk("t2_idle_sw_req", sw_req, 1'b0);

        // Fill to DEPTH without grant, overflow push, then push+pop while full.
        drive(1, mk(T_HEAD), 1'b0, 0, 3'd2, 1'b0);
        drive(1, mk(T_BODY), 1'b0, 0, 3'd2, 1'b0);
        drive(1, mk(T_BODY), 1'b0, 0, 3'd2, 1'b0);
        drive(1, mk(T_BODY), 1'b0, 0, 3'd2, 1'b0);
        drive(1, mk(T_BODY), 1'b0, 0, 3'd2, 1'b0); look();
        chk("t3_full_count", count, 3'd4);
        chk("t3_err_before", err, 1'b0);
        drive(1, mk(T_TAIL), 1'b0, 1, 3'd2, 1'b0); look();
        chk("t3_drop_count", count, 3'd4);
        chk("t3_drop_err", err, 1'b1);
        chk("t4_pop_valid", out_valid, 1'b1);
        drive(0, '0, 1'b0, 1, 3'd2, 1'b0); look();
        chk("t4_count_stays", count, 3'd4);
        repeat (4) drive(0, '0, 1'b0, 1, 3'd2, 1'b0);
        look();
        chk("t4_drained", count, 3'd0);

        // Orphan body flit as first arrival, then a normal head.
        do_reset();
        drive(1, mk(T_BODY), 1'b0, 0, 3'd0, 1'b0); look();
        chk("t5_c0_rc_en", rc_en, 1'b0);
        f0 = mk(T_HT);
        drive(1, f0, 1'b1, 0, 3'd3, 1'b0); look();
        chk("t5_c1_credit", credit_out, 1'b1);
        chk("t5_c1_rc_en", rc_en, 1'b0);
        chk("t5_c1_out_valid", out_valid, 1'b0);
        drive(0, '0, 1'b0, 0, 3'd3, 1'b0); look();
        chk("t5_c2_err", err, 1'b1);
        chk("t5_c2_rc_en", rc_en, 1'b0);
        drive(0, '0, 1'b0, 0, 3'd3, 1'b0); look();
        chk("t5_c3_rc_en", rc_en, 1'b1);
        drive(0, '0, 1'b0, 1, 3'd0, 1'b0); look();
        chk("t5_c4_out_valid", out_valid, 1'b1);
        chk("t5_c4_sw_port", sw_port, 3'd3);

        // Asynchronous reset in the middle of a packet.
        drive(1, mk(T_HEAD), 1'b0, 0, 3'd1, 1'b0);
        drive(1, mk(T_BODY), 1'b0, 0, 3'd1, 1'b0);
        drive(1, mk(T_BODY), 1'b0, 1, 3'd1, 1'b0);
        drive(0, '0, 1'b0, 0, 3'd1, 1'b0); look();
        chk("t6_pre_count", count, 3'd2);
        chk("t6_pre_sw_req", sw_req, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_count", count, 3'd0);
        chk("t6_rst_sw_req", sw_req, 1'b0);
        chk("t6_rst_err", err, 1'b0);
        chk("t6_rst_sw_port", sw_port, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, mk(T_HT), 1'b0, 0, 3'd2, 1'b0); look();
        chk("t6_c0_rc_en", rc_en, 1'b0);
        drive(0, '0, 1'b0, 0, 3'd2, 1'b0); look();
        chk("t6_c1_rc_en", rc_en, 1'b1);
        drive(0, '0, 1'b0, 1, 3'd0, 1'b0); look();
        chk("t6_c2_sw_req", sw_req, 1'b1);
        chk("t6_c2_out_valid", out_valid, 1'b1);

        // Randomized packet traffic checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic v;
            logic [FLIT_W-1:0] junk;
            if (pend.size() == 0) begin
                if ($urandom_range(0, 9) == 0) begin
                    pend.push_back(mk($urandom_range(0, 1) ? T_TAIL : T_BODY));
                end else begin
                    int len;
                    len = $urandom_range(1, 4);
                    if (len == 1) pend.push_back(mk(T_HT));
                    else begin
                        pend.push_back(mk(T_HEAD));
                        for (int b = 0; b < len - 2; b++) pend.push_back(mk(T_BODY));
                        pend.push_back(mk(T_TAIL));
                    end
                end
            end
            v = ($urandom_range(0, 9) < 7);
            junk = mk(2'($urandom_range(0, 3)));
            drive(v, v ? pend[0] : junk, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 6), 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            if (v) void'(pend.pop_front());
        end

        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
